// File: rtl/led_pkg.sv
// Shared types and widths for the LED breathing block.
package led_pkg;

    localparam int unsigned DUTY_W     = 16;
    localparam int unsigned DUTY_SUM_W = DUTY_W + 1;
    localparam int unsigned STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD_HI   = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_HOLD_LO   = 3'd4
    } led_state_e;

endpackage : led_pkg

// File: rtl/led_breath_pwm_gen.sv
// PWM generator: period counter, shadow duty loaded at the period boundary,
// registered compare output and period-boundary pulse.
module pwm_gen
    import led_pkg::*;
#(
    parameter logic [DUTY_W-1:0] PWM_MAX = 16'd499
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty_nxt,
    output logic              led_out,
    output logic [DUTY_W-1:0] duty_o,
    output logic              cyc_end
);

    logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DUTY_W-1:0] duty_act_q, duty_act_d;
    logic              led_q, led_d;
    logic              cyc_end_q, cyc_end_d;
    logic              at_max_c;

    assign at_max_c = (pwm_cnt_q == PWM_MAX);

    // Next-state for counter, shadow duty, compare output and boundary pulse.
    always_comb begin
        pwm_cnt_d  = '0;
        duty_act_d = '0;
        led_d      = 1'b0;
        cyc_end_d  = 1'b0;
        if (en) begin
            pwm_cnt_d  = at_max_c ? '0 : pwm_cnt_q + DUTY_W'(1);
            // Duty changes only at the boundary so a period is never split.
            duty_act_d = at_max_c ? duty_nxt : duty_act_q;
            led_d      = (pwm_cnt_q < duty_act_q);
            cyc_end_d  = at_max_c;
        end
    end

    // State registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt_q  <= '0;
            duty_act_q <= '0;
            led_q      <= 1'b0;
            cyc_end_q  <= 1'b0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            duty_act_q <= duty_act_d;
            led_q      <= led_d;
            cyc_end_q  <= cyc_end_d;
        end
    end

    assign led_out = led_q;
    assign duty_o  = duty_act_q;
    assign cyc_end = cyc_end_q;

endmodule : pwm_gen

// File: rtl/led_breath.sv
// LED breathing controller: ramps the PWM duty up, dwells at full, ramps
// down, dwells at off, and repeats, advancing one step per tick_in.
module led_breath
    import led_pkg::*;
#(
    parameter logic [DUTY_W-1:0] PWM_MAX    = 16'd499,
    parameter logic [DUTY_W-1:0] STEP       = 16'd5,
    parameter logic [DUTY_W-1:0] HOLD_TICKS = 16'd49
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              en,
    input  logic              tick_in,
    output logic              led_out,
    output logic [DUTY_W-1:0] duty_o,
    output logic              cyc_end
);

    localparam logic [DUTY_SUM_W-1:0] DUTY_FULL = DUTY_SUM_W'(PWM_MAX) + DUTY_SUM_W'(1);

    led_state_e        state_q, state_d;
    logic [DUTY_W-1:0] duty_nxt_q, duty_nxt_d;
    logic [DUTY_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DUTY_SUM_W-1:0] up_sum_c;

    // Widened so the ramp-up sum can never wrap.
    assign up_sum_c = DUTY_SUM_W'(duty_nxt_q) + DUTY_SUM_W'(STEP);

    // Breathing sequencer: state, target duty and dwell counter.
    always_comb begin
        state_d    = state_q;
        duty_nxt_d = duty_nxt_q;
        hold_cnt_d = hold_cnt_q;
        if (!en) begin
            state_d    = ST_IDLE;
            duty_nxt_d = '0;
            hold_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (tick_in) begin
                        if (up_sum_c >= DUTY_FULL) begin
                            duty_nxt_d = DUTY_W'(DUTY_FULL);
                            state_d    = ST_HOLD_HI;
                        end else begin
                            duty_nxt_d = DUTY_W'(up_sum_c);
                        end
                    end
                end
                ST_RAMP_DOWN: begin
                    if (tick_in) begin
                        if (duty_nxt_q <= STEP) begin
                            duty_nxt_d = '0;
                            state_d    = ST_HOLD_LO;
                        end else begin
                            duty_nxt_d = duty_nxt_q - STEP;
                        end
                    end
                end
                ST_HOLD_HI, ST_HOLD_LO: begin
                    if (tick_in) begin
                        if (hold_cnt_q == HOLD_TICKS) begin
                            hold_cnt_d = '0;
                            state_d    = (state_q == ST_HOLD_HI) ? ST_RAMP_DOWN : ST_RAMP_UP;
                        end else begin
                            hold_cnt_d = hold_cnt_q + DUTY_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    duty_nxt_d = '0;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // Sequencer registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            duty_nxt_q <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            duty_nxt_q <= duty_nxt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    pwm_gen #(
        .PWM_MAX (PWM_MAX)
    ) u_pwm_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .duty_nxt  (duty_nxt_q),
        .led_out   (led_out),
        .duty_o    (duty_o),
        .cyc_end   (cyc_end)
    );

endmodule : led_breath

// File: tb/tb_led_breath.sv
// Bench for led_breath: two instances (STEP=2 and STEP=3) checked every cycle
// against a trajectory-based model, plus directed literal expectations.
module tb_led_breath;

    localparam int PMAX  = 9;
    localparam int PHOLD = 1;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        en;
    logic        tick_in;
    logic        led0, led1;
    logic        cyc0, cyc1;
    logic [15:0] duty0, duty1;

    led_breath #(.PWM_MAX(16'd9), .STEP(16'd2), .HOLD_TICKS(16'd1)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .tick_in(tick_in),
        .led_out(led0), .duty_o(duty0), .cyc_end(cyc0)
    );

    led_breath #(.PWM_MAX(16'd9), .STEP(16'd3), .HOLD_TICKS(16'd1)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .tick_in(tick_in),
        .led_out(led1), .duty_o(duty1), .cyc_end(cyc1)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the duty target walks a precomputed cyclic trajectory, one
    // entry per accepted tick; the PWM is plain period arithmetic.
    int  ptrn [2][$];
    int  m_idx [2];
    bit  m_started [2];
    int  m_cnt [2];
    int  m_act [2];
    int  m_led [2];
    int  m_cyc [2];

    function automatic int pstep(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    task automatic build(input int i);
        int d;
        int full;
        full = PMAX + 1;
        d = 0;
        do begin
            d = (d + pstep(i) > full) ? full : d + pstep(i);
            ptrn[i].push_back(d);
        end while (d != full);
        for (int k = 0; k <= PHOLD; k++) ptrn[i].push_back(full);
        do begin
            d = (d <= pstep(i)) ? 0 : d - pstep(i);
            ptrn[i].push_back(d);
        end while (d != 0);
        for (int k = 0; k <= PHOLD; k++) ptrn[i].push_back(0);
    endtask

    function automatic int dn(input int i);
        return (m_idx[i] < 0) ? 0 : ptrn[i][m_idx[i]];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_idx[i] = -1; m_started[i] = 1'b0;
            m_cnt[i] = 0;  m_act[i] = 0; m_led[i] = 0; m_cyc[i] = 0;
        end
    endtask

    initial model_reset();

    // Model step plus per-cycle comparison, 1 time unit after each edge.
    always begin
        @(posedge sys_clk or negedge sys_rst_n);
        if (!sys_rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                int oc, oa, od;
                oc = m_cnt[i]; oa = m_act[i]; od = dn(i);
                if (!en) begin
                    m_cnt[i] = 0; m_act[i] = 0; m_led[i] = 0; m_cyc[i] = 0;
                    m_idx[i] = -1; m_started[i] = 1'b0;
                end else begin
                    m_cyc[i] = (oc == PMAX) ? 1 : 0;
                    m_led[i] = (oc < oa) ? 1 : 0;
                    m_act[i] = (oc == PMAX) ? od : oa;
                    m_cnt[i] = (oc == PMAX) ? 0 : oc + 1;
                    if (!m_started[i]) m_started[i] = 1'b1;
                    else if (tick_in) m_idx[i] = (m_idx[i] + 1) % ptrn[i].size();
                end
            end
        end
        #1;
        check("led0", int'(led0), m_led[0]);
        check("duty0", int'(duty0), m_act[0]);
        check("cyc0", int'(cyc0), m_cyc[0]);
        check("led1", int'(led1), m_led[1]);
        check("duty1", int'(duty1), m_act[1]);
        check("cyc1", int'(cyc1), m_cyc[1]);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_tick();
        @(negedge sys_clk) tick_in = 1'b1;
        @(negedge sys_clk) tick_in = 1'b0;
    endtask

    task automatic count_period(output int hi0, output int hi1, output int ce0);
        hi0 = 0; hi1 = 0; ce0 = 0;
        repeat (10) begin
            @(negedge sys_clk);
            hi0 += int'(led0); hi1 += int'(led1); ce0 += int'(cyc0);
        end
    endtask

    initial begin
        int hi0, hi1, ce0;
        bit found;
        en = 1'b0; tick_in = 1'b0; sys_rst_n = 1'b0;
        build(0); build(1);
        // Pin the trajectory construction with hand-derived values.
        check("ptrn0_len", ptrn[0].size(), 14);
        check("ptrn0_full", ptrn[0][4], 10);
        check("ptrn0_down", ptrn[0][8], 6);
        check("ptrn1_len", ptrn[1].size(), 12);
        check("ptrn1_nine", ptrn[1][2], 9);
        check("ptrn1_sat", ptrn[1][3], 10);
        check("ptrn1_low", ptrn[1][8], 1);

        cycles(3);
        check("rst_led0", int'(led0), 0);
        check("rst_duty0", int'(duty0), 0);
        sys_rst_n = 1'b1;
        cycles(2);
        en = 1'b1;
        cycles(5);
        pulse_tick(); cycles(30);
        check("t1_duty0", int'(duty0), 2);
        check("t1_duty1", int'(duty1), 3);
        pulse_tick(); cycles(30);
        check("t2_duty0", int'(duty0), 4);
        count_period(hi0, hi1, ce0);
        check("d4_high", hi0, 4);
        check("d4_cycend", ce0, 1);
        check("d6_high1", hi1, 6);
        pulse_tick(); cycles(30);
        check("t3_duty0", int'(duty0), 6);

        // Drop enable mid-ramp at duty 6.
        @(negedge sys_clk) en = 1'b0;
        @(negedge sys_clk);
        check("endrop_led0", int'(led0), 0);
        check("endrop_duty0", int'(duty0), 0);
        check("endrop_cyc0", int'(cyc0), 0);
        cycles(5);
        count_period(hi0, hi1, ce0);
        check("off_high0", hi0, 0);
        en = 1'b1;
        cycles(5);
        pulse_tick(); cycles(30);
        check("restart_duty0", int'(duty0), 2);

        // Tick coincident with the last count of the period.
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge sys_clk);
            if (m_cnt[0] == PMAX) found = 1'b1;
        end
        check("coinc_found", int'(found), 1);
        tick_in = 1'b1;
        @(negedge sys_clk) tick_in = 1'b0;
        check("coinc_old0", int'(duty0), 2);
        check("coinc_old1", int'(duty1), 3);
        cycles(10);
        check("coinc_new0", int'(duty0), 4);
        check("coinc_new1", int'(duty1), 6);

        pulse_tick(); cycles(30);
        check("t4_duty1", int'(duty1), 9);
        pulse_tick(); cycles(30);
        check("sat_duty1", int'(duty1), 10);
        count_period(hi0, hi1, ce0);
        check("full_high1", hi1, 10);
        check("d8_high0", hi0, 8);
        pulse_tick(); cycles(30);
        check("full_duty0", int'(duty0), 10);

        // Asynchronous reset mid-operation.
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check("arst_led0", int'(led0), 0);
        check("arst_duty0", int'(duty0), 0);
        check("arst_cyc0", int'(cyc0), 0);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        cycles(5);
        pulse_tick(); cycles(30);
        check("postrst_duty0", int'(duty0), 2);

        // Randomized phase: varying tick rates, enable drops and resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge sys_clk);
            if (c % 1000 < 150) tick_in = 1'b1;
            else tick_in = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 599) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            if ($urandom_range(0, 1499) == 0) sys_rst_n = 1'b0;
            else sys_rst_n = 1'b1;
        end
        tick_in = 1'b0;
        sys_rst_n = 1'b1;
        cycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_led_breath

// File: doc/led_breath.md
LED_BREATH -- requirements
Module: led_breath

Interface
REQ-001 The parameter PWM_MAX SHALL be 16-bit, default 16'd499, and set the PWM period to PWM_MAX+1 sys_clk cycles; legal range is 1..16'hFFFE.
REQ-002 The parameter STEP SHALL be 16-bit, default 16'd5, and set the duty increment/decrement per tick; legal range is 1..PWM_MAX+1.
REQ-003 The parameter HOLD_TICKS SHALL be 16-bit, default 16'd49, and define a dwell at full/off of HOLD_TICKS+1 ticks.
REQ-004 sys_clk  in  1  system clock; all logic is clocked on the rising edge.
REQ-005 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  breathing enable; level input, synchronous to sys_clk.
REQ-007 tick_in  in  1  single-cycle step pulse from the upstream period counter stage; it may arrive at any rate.
REQ-008 led_out  out  1  registered PWM output; 1 means LED on.
REQ-009 duty_o  out  16  currently applied duty (duty_act), range 0..PWM_MAX+1.
REQ-010 cyc_end  out  1  registered single-cycle pulse marking each PWM period boundary.

Function
REQ-011 pwm_cnt SHALL count 0..PWM_MAX and wrap to 0 while en=1, and SHALL be held at 0 while en=0.
REQ-012 led_out SHALL register (pwm_cnt < duty_act), giving one cycle of latency from the compare to the output.
REQ-013 duty_act SHALL load duty_nxt only on the cycle where pwm_cnt==PWM_MAX, so duty changes only at period boundaries and PWM never glitches.
REQ-014 cyc_end SHALL be 1 for exactly the cycle after each cycle with pwm_cnt==PWM_MAX and en=1.
REQ-015 The FSM SHALL have the states IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN and HOLD_LO.
REQ-016 FSM transition IDLE->RAMP_UP SHALL occur on the first edge with en=1; a tick_in on that same edge SHALL be ignored.
REQ-017 In RAMP_UP, on tick_in: if duty_nxt+STEP >= PWM_MAX+1, duty_nxt SHALL become PWM_MAX+1 and the FSM SHALL go to HOLD_HI; otherwise duty_nxt SHALL become duty_nxt+STEP. The sum is 17-bit and no wrap is permitted.
REQ-018 In RAMP_DOWN, on tick_in: if duty_nxt <= STEP, duty_nxt SHALL become 0 and the FSM SHALL go to HOLD_LO; otherwise duty_nxt SHALL become duty_nxt-STEP. No underflow is permitted.
REQ-019 In HOLD_HI/HOLD_LO, on tick_in: if hold_cnt==HOLD_TICKS, hold_cnt SHALL clear to 0 and the FSM SHALL go to RAMP_DOWN/RAMP_UP respectively; otherwise hold_cnt SHALL increment.
REQ-020 In every state, en=0 SHALL force the FSM to IDLE and clear duty_nxt, duty_act, hold_cnt and pwm_cnt to 0 on the next edge; led_out SHALL be 0 from that edge on.
REQ-021 When tick_in and pwm_cnt==PWM_MAX coincide, duty_act SHALL load the pre-update duty_nxt, and the new duty_nxt SHALL apply in the following period.
REQ-022 duty_act==PWM_MAX+1 SHALL give led_out constantly 1, and duty_act==0 SHALL give led_out constantly 0.
REQ-023 tick_in SHALL have no effect in IDLE.

Reset
REQ-024 Asserting sys_rst_n low SHALL immediately clear led_out, duty_o, cyc_end, pwm_cnt, duty_nxt and hold_cnt to 0 and set the FSM to IDLE, including when reset is asserted mid-ramp.
REQ-025 After reset release with en=1, the block SHALL resume from IDLE->RAMP_UP with duty 0, and no state is retained across reset.

Structure
REQ-026 The FSM state encodings (3-bit) and the 16-bit duty width constant SHALL live in a shared led_pkg include file.
REQ-027 The PWM counter, compare, shadow duty load and cyc_end SHALL be a sub-module pwm_gen; the FSM and hold/duty stepping SHALL stay in led_breath.

Verification
All scenarios use PWM_MAX=9, STEP=2, HOLD_TICKS=1, with tick_in pulsed every 20 cycles unless stated.
REQ-028 Reset asserted mid-operation -> led_out, duty_o and cyc_end are 0 asynchronously, and after release with en=1 the ramp restarts from duty 0.
REQ-029 en=1 -> duty_nxt sequence 2,4,6,8,10 on successive ticks; HOLD_HI lasts 2 ticks; then 8,6,4,2,0, HOLD_LO lasts 2 ticks, and the cycle repeats.
REQ-030 duty_act=4 steady -> led_out high exactly 4 of every 10 cycles, and cyc_end pulses every 10 cycles.
REQ-031 duty_act=10 -> led_out constantly 1; duty_act=0 -> led_out constantly 0; STEP=3 from duty 9 -> saturates at 10, no wrap.
REQ-032 en dropped at duty 6 in RAMP_UP -> led_out=0 and duty_o=0 after one edge; en re-raised -> ramp restarts at 2 on the first tick.
REQ-033 tick_in coincident with pwm_cnt==9 -> duty_o holds the old value this period and shows the new value at the next boundary.
